sha256_stream_padder: RTL and testbench
=======================================

// Module: sha256_stream_padder
// PURPOSE
//  Streaming SHA-256 message padder. Takes a message as a valid/ready stream of IN_W-bit beats.
//  Emits 512-bit padded blocks on a registered valid/ready output, in order: data, 0x80,
//  zero fill, then the 64-bit big-endian bit length. Handles any number of blocks.
//  Sits between the header/nonce source and the sha256 compression core.
// PARAMETERS
//  IN_W        32   input beat width in bits; one of 8,16,32,64,128,256,512
//  BYTE_CNT_W  61   message byte counter width; length field = {cnt,3'b0} zero-extended to 64 bits
// PORTS
//  clk        in   1                  clock, all logic on rising edge
//  rst        in   1                  synchronous reset, active-high
//  in_valid   in   1                  input beat valid
//  in_ready   out  1                  input beat accepted when in_valid & in_ready
//  in_data    in   IN_W               message beat; bit IN_W-1 is the first message bit
//  in_last    in   1                  beat is the final beat of the message
//  in_bytes   in   $clog2(IN_W/8)+1   valid bytes (MSB-aligned) on last beat, 0..IN_W/8
//  out_valid  out  1                  out_block valid
//  out_ready  in   1                  block consumed when out_valid & out_ready
//  out_block  out  512                padded block; bit 511 = first bit of block
//  out_last   out  1                  block is the final block of the message
// BEHAVIOUR
//  - Reset values: state=FILL, out_valid=0, out_last=0, out_block=0, byte_cnt=0, byte offset=0. in_ready=1.
//  - Reset mid-operation discards the partial block and any pending output. No block is emitted for it.
//  - in_ready = (state==FILL). It is combinational from state only and never depends on in_valid.
//  - Non-last beats are always full (IN_W/8 bytes). in_bytes is ignored on them.
//  - On a last beat, in_bytes > IN_W/8 is treated as IN_W/8. in_bytes=0 is legal (empty tail or empty message).
//  - Data is packed MSB-first at byte offset off (0..63). Bytes past in_bytes in a last beat are written as 0.
//  - byte_cnt is incremented by the bytes taken. It wraps mod 2^BYTE_CNT_W.
//  - Output register: out_block, out_valid and out_last are loaded on the edge that accepts the completing beat.
//    They are visible the next cycle (latency 1). They are held stable while out_valid & !out_ready.
//  - States:
//    FILL: accept beats.
//      -> OUT_MID if a non-last beat fills the block (off reaches 64).
//      -> OUT_FINAL on a last beat with final off <= 55. The 0x80 byte goes at off, bytes 56..63 = length.
//      -> OUT_EXTRA on a last beat with off in 56..63 (0x80 at off, rest 0) or off == 64 (no 0x80 yet).
//    OUT_MID: out_valid=1, out_last=0. On handshake: clear buffer, off=0 -> FILL.
//    OUT_EXTRA: out_valid=1, out_last=0. On handshake: load the length block -> OUT_FINAL.
//      Length block = 0x80 in byte 0 if the prior off was 64, else zeros; length in bytes 56..63.
//    OUT_FINAL: out_valid=1, out_last=1. On handshake: clear buffer, byte_cnt=0, off=0 -> FILL.
//  - The length field is the count of this message only. It counts bits, big-endian, in out_block[63:0].
//  - Beats can straddle the 448-bit boundary only via the OUT_EXTRA path. IN_W divides 512, so beats never straddle 512.
//  - No simultaneous input/output activity: input is stalled while any block is pending.
//    The throughput bubble this causes is accepted.
// TESTING
//  1 IN_W=32, "abc": one beat 0x61626300, in_bytes=3, last -> one block, out_last=1:
//    0x61626380, zeros, out_block[63:0]=0x18.
//  2 Empty message: in_last=1, in_bytes=0 -> one block: bit 511=1, all else 0, length 0, out_last=1.
//  3 55-byte message -> single block: byte 55=0x80, length 0x1B8.
//    56-byte message -> two blocks: block1 has byte 56=0x80, out_last=0; block2 all zero except length 0x1C0.
//  4 64-byte message (16 beats, last in_bytes=4) -> block1 = data, out_last=0;
//    block2 = 0x80 at byte 0, length 0x200, out_last=1.
//  5 Backpressure: hold out_ready=0 for 5 cycles on each block of a 3-block message.
//    Require out_block stable, in_ready=0 throughout, and no lost or duplicated blocks.
//    Compare the digest path against a software SHA-256.
//  6 Assert rst for 1 cycle after 7 beats of a message, then send "abc" -> only the "abc" block appears, length 0x18.

Source files
------------

// File: rtl/sha256_stream_padder_if.sv
// rtl/sha256_stream_padder_if.sv - message beat input and padded block output bundle
interface sha256_stream_padder_if #(
  parameter int IN_W = 32
);
  localparam int BYTES_W = $clog2(IN_W / 8) + 1;

  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    in_data;
  logic               in_last;
  logic [BYTES_W-1:0] in_bytes;
  logic               out_valid;
  logic               out_ready;
  logic [511:0]       out_block;
  logic               out_last;

  modport master (
    output in_valid, in_data, in_last, in_bytes, out_ready,
    input  in_ready, out_valid, out_block, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, out_ready,
    output in_ready, out_valid, out_block, out_last
  );
endinterface

// File: rtl/sha256_stream_padder.sv
// rtl/sha256_stream_padder.sv - streaming SHA-256 message padder producing 512-bit blocks
// The fill buffer doubles as the output register; input stalls whenever a block is pending.
module sha256_stream_padder #(
  parameter int IN_W       = 32,
  parameter int BYTE_CNT_W = 61
) (
  input logic                   clk,
  input logic                   rst,
  sha256_stream_padder_if.slave bus
);
  localparam int                 BEAT_BYTES = IN_W / 8;
  localparam int                 BYTES_W    = $clog2(BEAT_BYTES) + 1;
  localparam logic [BYTES_W-1:0] FULL       = BYTES_W'(BEAT_BYTES);
  localparam logic [511:0]       MARK0      = 512'h80 << 504;

  typedef enum logic [1:0] {FILL, OUT_MID, OUT_EXTRA, OUT_FINAL} state_t;

  state_t                state;
  logic [511:0]          blk;
  logic [6:0]            off;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic                  extra_marker;
  logic                  out_valid_r;
  logic                  out_last_r;

  logic [BYTES_W-1:0]    take;
  logic [IN_W-1:0]       masked;
  logic [511:0]          placed;
  logic [511:0]          marker;
  logic [511:0]          merged;
  logic [6:0]            new_off;
  logic [BYTE_CNT_W-1:0] new_cnt;
  logic [63:0]           new_len;
  logic [63:0]           cur_len;
  logic                  accept;
  logic                  out_fire;

  assign bus.in_ready  = (state == FILL);
  assign bus.out_valid = out_valid_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_block = blk;
  assign accept        = bus.in_valid && (state == FILL);
  assign out_fire      = out_valid_r && bus.out_ready;

  always_comb begin
    take = FULL;
    if (bus.in_last && (bus.in_bytes < FULL)) take = bus.in_bytes;
    masked = '0;
    for (int i = 0; i < BEAT_BYTES; i++) begin
      if (i < int'(take)) masked[IN_W-1-8*i -: 8] = bus.in_data[IN_W-1-8*i -: 8];
    end
    // Buffer bytes at and beyond off are always zero here, so OR-merging is enough.
    placed  = (512'(masked) << (512 - IN_W)) >> {off, 3'b000};
    new_off = off + 7'(take);
    marker  = (new_off < 7'd64) ? (MARK0 >> {new_off, 3'b000}) : '0;
    merged  = blk | placed;
    new_cnt = byte_cnt + BYTE_CNT_W'(take);
    new_len = 64'({new_cnt, 3'b000});
    cur_len = 64'({byte_cnt, 3'b000});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILL;
      blk          <= '0;
      off          <= '0;
      byte_cnt     <= '0;
      extra_marker <= 1'b0;
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            byte_cnt <= new_cnt;
            off      <= new_off;
            if (bus.in_last && (new_off <= 7'd55)) begin
              blk         <= merged | marker | 512'(new_len);
              out_valid_r <= 1'b1;
              out_last_r  <= 1'b1;
              state       <= OUT_FINAL;
            end else if (bus.in_last) begin
              blk          <= merged | marker;
              extra_marker <= (new_off == 7'd64);
              out_valid_r  <= 1'b1;
              state        <= OUT_EXTRA;
            end else if (new_off == 7'd64) begin
              blk         <= merged;
              out_valid_r <= 1'b1;
              state       <= OUT_MID;
            end else begin
              blk <= merged;
            end
          end
        end
        OUT_MID: begin
          if (out_fire) begin
            blk         <= '0;
            off         <= '0;
            out_valid_r <= 1'b0;
            state       <= FILL;
          end
        end
        OUT_EXTRA: begin
          // Length-only block; carries the 0x80 only if the data ended exactly on a block edge.
          if (out_fire) begin
            blk        <= (extra_marker ? MARK0 : '0) | 512'(cur_len);
            out_last_r <= 1'b1;
            state      <= OUT_FINAL;
          end
        end
        OUT_FINAL: begin
          if (out_fire) begin
            blk         <= '0;
            off         <= '0;
            byte_cnt    <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            state       <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_stream_padder.sv
// tb/tb_sha256_stream_padder.sv - directed self-checking bench for sha256_stream_padder
module tb_sha256_stream_padder;
  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   bp          = 1'b0;

  logic [7:0]   msg   [$];
  logic [512:0] exp_q [$];
  logic [512:0] got_q [$];

  localparam logic [255:0] H0 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_stream_padder_if #(.IN_W(32)) bus ();
  sha256_stream_padder #(.IN_W(32), .BYTE_CNT_W(61)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_block(input logic [255:0] h, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = m[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic build_expected();
    logic [7:0]   p [$];
    logic [63:0]  bits;
    logic [511:0] b;
    int           nblk;
    p    = msg;
    bits = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nblk = p.size() / 64;
    for (int k = 0; k < nblk; k++) begin
      for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*k+j];
      exp_q.push_back({(k == nblk - 1), b});
    end
  endtask

  task automatic send_msg(input int last_override);
    int n     = msg.size();
    int beats = (n == 0) ? 1 : (n + 3) / 4;
    for (int bt = 0; bt < beats; bt++) begin
      logic [31:0] d;
      int          budget = 0;
      for (int k = 0; k < 4; k++) begin
        if (bt * 4 + k < n) d[31-8*k -: 8] = msg[bt*4+k];
        else                d[31-8*k -: 8] = 8'hA5;
      end
      while (bus.in_ready !== 1'b1 && budget < 1000) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
        budget++;
      end
      check("in_ready_wait", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = (bt == beats - 1);
      if (bt == beats - 1) bus.in_bytes = 3'((last_override >= 0) ? last_override : n - bt * 4);
      else                 bus.in_bytes = 3'd1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run_msg(input string tag, input int last_override);
    int budget = 0;
    got_q.delete();
    exp_q.delete();
    build_expected();
    send_msg(last_override);
    while ((got_q.size() < exp_q.size() || bus.out_valid !== 1'b0) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_block%0d", tag, i), got_q[i][511:0], exp_q[i][511:0]);
      check($sformatf("%s_last%0d", tag, i), got_q[i][512], exp_q[i][512]);
    end
  endtask

  initial begin : sink
    logic [511:0] snap;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.out_valid === 1'b1) begin
        if (bp) begin
          bus.out_ready = 1'b0;
          snap = bus.out_block;
          repeat (5) begin
            @(negedge clk);
            check("stall_block_stable", bus.out_block, snap);
            check("stall_in_ready", bus.in_ready, 0);
          end
          bus.out_ready = 1'b1;
        end
        got_q.push_back({bus.out_last, bus.out_block});
      end
    end
  end

  initial begin : stim
    string        s;
    logic [255:0] h;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.in_bytes = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_last", bus.out_last, 0);
    check("reset_out_block", bus.out_block, 0);

    msg = '{8'h61, 8'h62, 8'h63};
    run_msg("abc", -1);
    check("abc_hand", got_q[0][511:0], {32'h61626380, 416'd0, 64'h18});
    check("abc_digest", sha_block(H0, got_q[0][511:0]),
          256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

    msg.delete();
    run_msg("empty", -1);
    check("empty_hand", got_q[0][511:0], 512'h1 << 511);
    check("empty_last", got_q[0][512], 1);

    msg = '{8'h61, 8'h62, 8'h63, 8'h64};
    run_msg("clamp", 7);
    check("clamp_hand", got_q[0][511:0], {32'h61626364, 8'h80, 408'd0, 64'h20});

    msg.delete();
    for (int i = 0; i < 55; i++) msg.push_back(8'(i + 1));
    run_msg("len55", -1);
    check("len55_marker", got_q[0][511-8*55 -: 8], 8'h80);
    check("len55_length", got_q[0][63:0], 64'h1B8);

    msg.push_back(8'd56);
    run_msg("len56", -1);
    check("len56_marker", got_q[0][511-8*56 -: 8], 8'h80);
    check("len56_last0", got_q[0][512], 0);
    check("len56_tail", got_q[1], {1'b1, 512'h1C0});

    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'(i * 3 + 5));
    run_msg("len64", -1);
    check("len64_last0", got_q[0][512], 0);
    check("len64_tail", got_q[1], {1'b1, (512'h80 << 504) | 512'h200});

    bp = 1'b1;
    s  = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    msg.delete();
    for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
    run_msg("nist56", -1);
    h = H0;
    foreach (got_q[i]) h = sha_block(h, got_q[i][511:0]);
    check("nist56_digest", h, 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);

    msg.delete();
    for (int i = 0; i < 120; i++) msg.push_back(8'(i * 7 + 3));
    run_msg("bp120", -1);
    bp = 1'b0;

    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      bus.in_last  = 1'b0;
      bus.in_bytes = 3'd4;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_block", bus.out_block, 0);
    msg = '{8'h61, 8'h62, 8'h63};
    run_msg("post_rst_abc", -1);
    check("post_rst_hand", got_q[0], {1'b1, 32'h61626380, 416'd0, 64'h18});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
